// File: rtl/seq_bla_subtractor_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_bla_subtractor_if
// Brief    : Valid/ready operand and result bundle for seq_bla_subtractor.
//            Carries ovf only when SEQ_BLA_SUB_OVF_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface seq_bla_subtractor_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SEQ_BLA_SUB_OVF_EN
    logic             ovf;
`endif

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout
`ifdef SEQ_BLA_SUB_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout
`ifdef SEQ_BLA_SUB_OVF_EN
        , output ovf
`endif
    );
endinterface
`default_nettype wire

// File: rtl/seq_bla_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : seq_bla_subtractor
// Brief    : Multi-cycle diff = a - b - bin, one 4-bit borrow-lookahead slice
//            per clock, LSB first. Optional overflow: SEQ_BLA_SUB_OVF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module seq_bla_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seq_bla_subtractor_if.slave  bus
);
    localparam int NSLICE  = WIDTH / 4;
    localparam int c_CNT_W = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(NSLICE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_diff;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_borrow;
    logic               r_bout;
    logic               r_in_ready;
    logic               r_out_valid;

    logic [3:0] w_sa;
    logic [3:0] w_sb;
    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [3:0] w_d;
    logic [4:0] w_bw;

    // Pick the active slice of the captured operands.
    always_comb begin
        w_sa = '0;
        w_sb = '0;
        for (int k = 0; k < NSLICE; k++) begin
            if (r_cnt == c_CNT_W'(k)) begin
                w_sa = r_a[4*k +: 4];
                w_sb = r_b[4*k +: 4];
            end
        end
    end

    assign w_g = ~w_sa & w_sb;
    assign w_p = ~(w_sa ^ w_sb);

    // Every slice borrow is a flat sum of products of g/p and the slice borrow-in.
    assign w_bw[0] = r_borrow;
    assign w_bw[1] = w_g[0] | (w_p[0] & r_borrow);
    assign w_bw[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & r_borrow);
    assign w_bw[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                   | (w_p[2] & w_p[1] & w_p[0] & r_borrow);
    assign w_bw[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                   | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                   | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & r_borrow);
    assign w_d = w_sa ^ w_sb ^ w_bw[3:0];

`ifdef SEQ_BLA_SUB_OVF_EN
    logic r_ovf;
    logic w_ovf;
    // w_d[3] is the result MSB only on the last slice, which is when it is sampled.
    assign w_ovf = (r_a[WIDTH-1] ^ r_b[WIDTH-1]) & (r_a[WIDTH-1] ^ w_d[3]);
    assign bus.ovf = r_ovf;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_diff      <= '0;
            r_cnt       <= '0;
            r_borrow    <= 1'b0;
            r_bout      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
`ifdef SEQ_BLA_SUB_OVF_EN
            r_ovf       <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_a        <= bus.a;
                        r_b        <= bus.b;
                        r_borrow   <= bus.bin;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    for (int k = 0; k < NSLICE; k++) begin
                        if (r_cnt == c_CNT_W'(k)) begin
                            r_diff[4*k +: 4] <= w_d;
                        end
                    end
                    r_borrow <= w_bw[4];
                    if (r_cnt == c_LAST) begin
                        r_bout      <= w_bw[4];
`ifdef SEQ_BLA_SUB_OVF_EN
                        r_ovf       <= w_ovf;
`endif
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.diff      = r_diff;
    assign bus.bout      = r_bout;
endmodule
`default_nettype wire

// File: tb/tb_seq_bla_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_bla_subtractor
// Brief    : Directed, table-driven bench for seq_bla_subtractor (WIDTH=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_bla_subtractor;
    localparam int WIDTH = 16;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    seq_bla_subtractor_if #(.WIDTH(WIDTH)) bus ();

    seq_bla_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        bin;
        logic [15:0] exp_diff;
        logic        exp_bout;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One full operation: accept, wait for result, compare, drain.
    task automatic do_op(input vec_t v, input string tag);
        int lat;
        @(negedge clk);
        bus.a        = v.a;
        bus.b        = v.b;
        bus.bin      = v.bin;
        bus.in_valid = 1'b1;
        check({tag, " in_ready"}, {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a        = 16'hDEAD;
        bus.b        = 16'hBEEF;
        bus.bin      = 1'b1;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'd4);
        check({tag, " diff"}, {16'd0, bus.diff}, {16'd0, v.exp_diff});
        check({tag, " bout"}, {31'd0, bus.bout}, {31'd0, v.exp_bout});
`ifdef SEQ_BLA_SUB_OVF_EN
        check({tag, " ovf"}, {31'd0, bus.ovf}, {31'd0, v.exp_ovf});
`endif
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({tag, " drain out_valid"}, {31'd0, bus.out_valid}, 32'd0);
        check({tag, " drain in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    endtask

    initial begin
        vec_t        v;
        logic [15:0] held_diff;
        int          lat;

        n_checks = 0;
        n_errors = 0;

        vecs[0]  = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[1]  = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vecs[2]  = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[3]  = '{16'h0005, 16'h0003, 1'b1, 16'h0001, 1'b0, 1'b0};
        vecs[4]  = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
        vecs[5]  = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
        vecs[6]  = '{16'h0003, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0};
        vecs[7]  = '{16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0, 1'b0};
        vecs[8]  = '{16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0};
        vecs[9]  = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[10] = '{16'h00FF, 16'h000F, 1'b0, 16'h00F0, 1'b0, 1'b0};

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.bin       = 1'b0;
        rst_n         = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("reset diff", {16'd0, bus.diff}, 32'd0);
        check("reset bout", {31'd0, bus.bout}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle with in_valid low: nothing is captured.
        repeat (3) @(posedge clk);
        #1;
        check("idle in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("idle out_valid", {31'd0, bus.out_valid}, 32'd0);

        for (int i = 0; i < 11; i++) begin
            do_op(vecs[i], $sformatf("vec%0d", i));
        end

        // Backpressure: result must hold while out_ready is low.
        v = '{16'h5678, 16'h1234, 1'b0, 16'h4444, 1'b0, 1'b0};
        @(negedge clk);
        bus.a = v.a; bus.b = v.b; bus.bin = v.bin; bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("bp latency", 32'(lat), 32'd4);
        held_diff = bus.diff;
        check("bp diff", {16'd0, held_diff}, 32'h4444);
        bus.a = 16'h0001; bus.b = 16'h0002; bus.bin = 1'b1; bus.in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp hold%0d", c),
                  {14'd0, bus.out_valid, bus.in_ready, bus.diff},
                  {14'd0, 1'b1, 1'b0, 16'h4444});
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("bp release out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("bp release in_ready", {31'd0, bus.in_ready}, 32'd1);
        do_op('{16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, 1'b0}, "bp second");

        // Reset two cycles after accept discards the in-flight result.
        @(negedge clk);
        bus.a = 16'hFFFF; bus.b = 16'h0001; bus.bin = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("midrst diff", {16'd0, bus.diff}, 32'd0);
        check("midrst bout", {31'd0, bus.bout}, 32'd0);
        check("midrst in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(vecs[10], "after reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/seq_bla_subtractor.md
Name: seq_bla_subtractor

Overview:
- Multi-cycle wide subtractor computing diff = a - b - bin over WIDTH bits.
- Processes one 4-bit borrow-lookahead slice per clock, LSB slice first, with the borrow carried between slices in a register.
- Companion to the 4-bit carry-lookahead adder in the arithmetic library, for datapaths needing wide subtraction at low area.
- Valid/ready handshake on both input and output sides.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4.
- NSLICE, WIDTH/4, derived slice count; not to be overridden.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow-in.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- diff  output  WIDTH  a - b - bin, modulo 2^WIDTH.
- bout  output  1  borrow-out; 1 when unsigned a < b + bin.

Behaviour:
- Reset (async assert, sync release): state=IDLE; in_ready=1; out_valid=0; diff=0; bout=0; slice counter=0; operand and borrow registers=0.
- State IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid & in_ready: capture a, b, bin into internal registers; counter=0; go to RUN.
- State RUN:
  - in_ready=0, out_valid=0.
  - Each cycle, slice k = bits [4k+3:4k] of the captured operands.
  - Per bit i: g=~a&b, p=~(a^b); borrow[i+1]=g | (p & borrow[i]); d=a^b^borrow[i].
  - All 4 borrows are computed in lookahead form, not rippled.
  - Write the slice difference into diff bits [4k+3:4k]; register the slice borrow-out as the next slice's borrow-in.
  - When k==NSLICE-1: bout=final borrow; go to DONE. Otherwise k=k+1.
- State DONE:
  - out_valid=1; diff and bout held stable.
  - On out_ready: go to IDLE; out_valid deasserts the next cycle.
  - in_ready=0 in DONE, so there is a 1-cycle bubble between back-to-back operations.
- Latency:
  - Operands accepted at edge T; out_valid rises at edge T+NSLICE (4 cycles for WIDTH=16).
  - Throughput: one result per NSLICE+2 cycles under continuous valid/ready.
- Partial results: diff bits of slices not yet processed hold their previous-operation value during RUN. diff is only meaningful while out_valid=1.
- Inputs a, b and bin are ignored outside the accept cycle; changes during RUN or DONE have no effect.
- in_valid deasserting while in_ready=1 is allowed; nothing is captured.
- out_ready held low keeps DONE indefinitely with outputs stable.
- Reset asserted mid-RUN or in DONE: immediately returns to the reset state; the in-flight result is discarded and out_valid drops.
- Wrap-around: the result is modulo 2^WIDTH; bout flags the unsigned underflow.

Optional Feature:
- Macro: SEQ_BLA_SUB_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit): two's-complement overflow = (a[MSB]^b[MSB]) & (a[MSB]^diff[MSB]), using captured operands.
  - ovf is registered together with bout when leaving RUN, valid alongside out_valid, and reset to 0.
- Undefined: port ovf and its logic are absent; all other behaviour is identical.

Test Plan:
- Basic, WIDTH=16: a=0x1234, b=0x0234, bin=0 -> diff=0x1000, bout=0; out_valid exactly 4 cycles after accept.
- Underflow wrap: a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1. Inter-slice borrow propagation through all 4 slices is exercised.
- Borrow-in: a=0xFFFF, b=0xFFFF, bin=1 -> diff=0xFFFF, bout=1. Then a=0x0005, b=0x0003, bin=1 -> diff=0x0001, bout=0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> diff/bout stable, in_ready=0, new in_valid ignored. Raise out_ready -> IDLE next cycle; a second op is accepted and is correct.
- Reset mid-RUN: assert rst_n=0 two cycles after accept -> out_valid=0, diff=0, bout=0, in_ready=1 immediately. The next op a=0x00FF, b=0x000F -> diff=0x00F0, bout=0.
- SEQ_BLA_SUB_OVF_EN: a=0x8000, b=0x0001 -> diff=0x7FFF, bout=0, ovf=1. a=0x7FFF, b=0xFFFF -> diff=0x8000, bout=1, ovf=1. a=0x0003, b=0x0001 -> ovf=0.
